fifo_vc_buffer: RTL and testbench

Multi-virtual-channel input buffer for a NoC router port. There are NUM_VC independent circular FIFOs behind one shared write port. Each channel has its own pull, head, occupancy counter and full/empty flags. It replaces the single-queue port buffer so that wormhole flits on different VCs cannot block each other.

---
 rtl/fifo_vc_buffer.sv | 104 ++++++++++
 tb/tb_fifo_vc_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_vc_buffer.sv
`default_nettype none
// ============================================================================
// fifo_vc_buffer : NUM_VC independent circular FIFOs behind one shared write
//                  port. Optional credit return enabled by FIFO_VC_CREDIT_EN.
// Revision 1.0
// ============================================================================
module fifo_vc_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int NUM_VC = 4,
  localparam int VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [VCW-1:0]          push_vc,
  input  logic [WIDTH-1:0]        tail,
  input  logic [NUM_VC-1:0]       pull,
  output logic [NUM_VC*WIDTH-1:0] head,
  output logic [NUM_VC*CW-1:0]    counter,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       empty,
  output logic                    push_err
`ifdef FIFO_VC_CREDIT_EN
  ,
  output logic [NUM_VC-1:0]       credit_out,
  output logic [CW-1:0]           credit_init
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_VC-1:0] hit;
  logic [NUM_VC-1:0] accept;
  logic [NUM_VC-1:0] pull_ok;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             full_r;
    logic             empty_r;

    // An out-of-range push_vc matches no channel, so it is never accepted.
    assign hit[v]     = push && (push_vc == VCW'(v));
    assign accept[v]  = hit[v] && (!full_r || pull[v]);
    assign pull_ok[v] = pull[v] && !empty_r;
    assign cnt_nxt    = cnt + CW'(accept[v]) - CW'(pull_ok[v]);

    always_ff @(posedge clock) begin
      if (!reset && accept[v])
        mem[wr] <= tail;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rd      <= '0;
        wr      <= '0;
        cnt     <= '0;
        full_r  <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        if (pull_ok[v])
          rd <= rd + AW'(1);
        if (accept[v])
          wr <= wr + AW'(1);
        cnt     <= cnt_nxt;
        full_r  <= (cnt_nxt == CW'(DEPTH));
        empty_r <= (cnt_nxt == '0);
      end
    end

    assign head[v*WIDTH +: WIDTH] = mem[rd];
    assign counter[v*CW +: CW]    = cnt;
    assign full[v]                = full_r;
    assign empty[v]               = empty_r;
  end

  always_ff @(posedge clock) begin
    if (reset)
      push_err <= 1'b0;
    else if (push && !(|accept))
      push_err <= 1'b1;
  end

`ifdef FIFO_VC_CREDIT_EN
  // One credit per flit actually removed, so ignored pulls return nothing.
  always_ff @(posedge clock) begin
    if (reset)
      credit_out <= '0;
    else
      credit_out <= pull_ok;
  end

  assign credit_init = CW'(DEPTH);
`else
  // No credit return path in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_vc_buffer.sv
`default_nettype none
// Testbench for fifo_vc_buffer: directed test-plan sequences plus random
// traffic, checked every cycle against a queue-based model.
module tb_fifo_vc_buffer;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int NUM_VC = 4;
  localparam int VCW    = 2;
  localparam int CW     = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    push = 1'b0;
  logic [VCW-1:0]          push_vc = '0;
  logic [WIDTH-1:0]        tail = '0;
  logic [NUM_VC-1:0]       pull = '0;
  logic [NUM_VC*WIDTH-1:0] head;
  logic [NUM_VC*CW-1:0]    counter;
  logic [NUM_VC-1:0]       full;
  logic [NUM_VC-1:0]       empty;
  logic                    push_err;
`ifdef FIFO_VC_CREDIT_EN
  logic [NUM_VC-1:0]       credit_out;
  logic [CW-1:0]           credit_init;
`endif

  fifo_vc_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_vc    (push_vc),
    .tail       (tail),
    .pull       (pull),
    .head       (head),
    .counter    (counter),
    .full       (full),
    .empty      (empty),
    .push_err   (push_err)
`ifdef FIFO_VC_CREDIT_EN
    ,
    .credit_out (credit_out),
    .credit_init(credit_init)
`endif
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0]  q [NUM_VC][$];
  bit                m_err = 1'b0;
  bit [NUM_VC-1:0]   m_credit = '0;
  bit                live = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int hd(input int v);
    return int'(head[v*WIDTH +: WIDTH]);
  endfunction

  function automatic int cn(input int v);
    return int'(counter[v*CW +: CW]);
  endfunction

  // Apply one cycle of inputs, then advance the model by the same edge.
  task automatic step(input bit rst, input bit p, input int vc, input int d,
                      input bit [NUM_VC-1:0] pl);
    bit [NUM_VC-1:0] pd;
    bit              acc;
    reset   = rst;
    push    = p;
    push_vc = vc[VCW-1:0];
    tail    = d[WIDTH-1:0];
    pull    = pl;
    @(posedge clock);
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) q[v].delete();
      m_err    = 1'b0;
      m_credit = '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) pd[v] = pl[v] && (q[v].size() > 0);
      acc = p && (vc < NUM_VC) && ((q[vc].size() < DEPTH) || pl[vc]);
      for (int v = 0; v < NUM_VC; v++) if (pd[v]) void'(q[v].pop_front());
      if (acc) q[vc].push_back(d[WIDTH-1:0]);
      if (p && !acc) m_err = 1'b1;
      m_credit = pd;
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (live) begin
      for (int v = 0; v < NUM_VC; v++) begin
        chk($sformatf("counter[%0d]", v), cn(v), q[v].size());
        chk($sformatf("full[%0d]", v), int'(full[v]), int'(q[v].size() == DEPTH));
        chk($sformatf("empty[%0d]", v), int'(empty[v]), int'(q[v].size() == 0));
        if (q[v].size() > 0)
          chk($sformatf("head[%0d]", v), hd(v), int'(q[v][0]));
      end
      chk("push_err", int'(push_err), int'(m_err));
`ifdef FIFO_VC_CREDIT_EN
      chk("credit_out", int'(credit_out), int'(m_credit));
`endif
    end
  end

  initial begin
    int exp_rd [8];
    bit rst;
    bit p;
    int vc;
    bit [NUM_VC-1:0] pl;

    step(1, 0, 0, 0, '0);
    live = 1'b1;
    chk("reset empty", int'(empty), 4'hF);
    chk("reset full", int'(full), 0);
    chk("reset push_err", int'(push_err), 0);
`ifdef FIFO_VC_CREDIT_EN
    chk("credit_init", int'(credit_init), DEPTH);
`endif

    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2, 8'hA1 + i, '0);
      chk("vc2 fill count", cn(2), i + 1);
      chk("vc2 fill head", hd(2), 8'hA1);
    end
    chk("vc2 full", int'(full[2]), 1);
    chk("others empty", int'(empty & 4'b1011), 4'b1011);

    step(0, 1, 2, 8'hFF, '0);
    chk("drop count", cn(2), 8);
    chk("drop push_err", int'(push_err), 1);

    step(0, 1, 2, 8'hB0, 4'b0100);
    chk("full push+pull head", hd(2), 8'hA2);
    chk("full push+pull count", cn(2), 8);
    chk("full push+pull full", int'(full[2]), 1);

    exp_rd = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hB0};
    for (int i = 0; i < 10; i++) begin
      if (i < 8) chk($sformatf("vc2 drain %0d", i), hd(2), exp_rd[i]);
      step(0, 0, 0, 0, 4'b0100);
    end
    chk("drain count", cn(2), 0);
    chk("drain empty", int'(empty[2]), 1);
    chk("drain push_err sticky", int'(push_err), 1);

    step(0, 1, 0, 8'h10, '0);
    step(0, 1, 3, 8'h30, '0);
    step(0, 1, 0, 8'h11, '0);
    step(0, 1, 3, 8'h31, '0);
    step(0, 0, 0, 0, 4'b1001);
    chk("vc0 head", hd(0), 8'h11);
    chk("vc3 head", hd(3), 8'h31);
    chk("vc0 count", cn(0), 1);
    chk("vc3 count", cn(3), 1);
`ifdef FIFO_VC_CREDIT_EN
    chk("dual credit", int'(credit_out), 4'b1001);
`endif

    step(0, 1, 1, 8'h40, '0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("vc1 stream %0d", i), hd(1), 8'h40 + i);
      step(0, 1, 1, 8'h41 + i, 4'b0010);
      chk("vc1 stream count", cn(1), 1);
    end

    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h50 + i, '0);
    chk("vc0 five", cn(0), 5);
    step(1, 1, 0, 8'h77, 4'b0001);
    chk("reset vc0 count", cn(0), 0);
    chk("reset vc0 empty", int'(empty[0]), 1);
    chk("reset clears push_err", int'(push_err), 0);

    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      p   = ($urandom_range(0, 99) < 60);
      vc  = $urandom_range(0, NUM_VC - 1);
      for (int v = 0; v < NUM_VC; v++) pl[v] = ($urandom_range(0, 99) < 35);
      step(rst, p, vc, $urandom_range(0, 255), pl);
    end

    step(0, 0, 0, 0, '0);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
